// File: rtl/mkio_word_decoder.sv
// Manchester-II receive decoder for one MIL-STD-1553B channel: qualifies the
// 3-bit-time sync, recovers 16 data bits plus odd parity, strobes one word per frame.
module mkio_word_decoder #(
   parameter int CLK_PER_HALF = 16,
   parameter int TOL          = 4,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        DI1,
   input  logic        DI0,
   output logic [15:0] rx_data,
   output logic        rx_cmd,
   output logic        rx_valid,
   output logic        rx_manch_err,
   output logic        rx_par_err,
   output logic        rx_busy
);

   localparam logic [CNT_W-1:0] H        = CNT_W'(CLK_PER_HALF);
   localparam logic [CNT_W-1:0] SAMP_1   = CNT_W'(CLK_PER_HALF / 2);
   localparam logic [CNT_W-1:0] SAMP_3   = CNT_W'(3 * CLK_PER_HALF / 2);
   localparam logic [CNT_W-1:0] SAMP_5   = CNT_W'(5 * CLK_PER_HALF / 2);
   localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(3 * CLK_PER_HALF - 1);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(2 * CLK_PER_HALF - 1);
   localparam logic [CNT_W-1:0] RUN_MIN  = CNT_W'(3 * CLK_PER_HALF - TOL);
   localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(4 * CLK_PER_HALF + TOL);
   localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(CLK_PER_HALF - TOL);
   localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(CLK_PER_HALF + TOL);

   typedef enum logic [1:0] {S_HUNT, S_SYNC2, S_DATA, S_DONE} state_t;

   // Bit 1 carries DI1, bit 0 carries DI0; the extra delayed stage gives the
   // pre-change value used by every sample point.
   logic [1:0] di_meta_reg, di_sync_reg, di_dly_reg;
   logic       lvl_s, act_s, lvl_d, act_d, edge_s;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] run_reg, run_next;
   logic [CNT_W-1:0] phase_reg, phase_next;
   logic [4:0]       bit_idx_reg, bit_idx_next;
   logic             pol_reg, pol_next;
   logic [15:0]      data_reg, data_next;
   logic             samp_a_reg, samp_a_next;
   logic             manch_reg, manch_next;
   logic [15:0]      rx_data_reg, rx_data_next;
   logic             rx_cmd_reg, rx_cmd_next;
   logic             rx_valid_reg, rx_valid_next;
   logic             rx_manch_reg, rx_manch_next;
   logic             rx_par_reg, rx_par_next;
   logic             rx_busy_reg, rx_busy_next;

   assign lvl_s  = di_sync_reg[1];
   assign act_s  = di_sync_reg[1] ^ di_sync_reg[0];
   assign lvl_d  = di_dly_reg[1];
   assign act_d  = di_dly_reg[1] ^ di_dly_reg[0];
   assign edge_s = act_s && (lvl_s != lvl_d);

   always_comb begin
      state_next    = state_reg;
      run_next      = run_reg;
      phase_next    = phase_reg;
      bit_idx_next  = bit_idx_reg;
      pol_next      = pol_reg;
      data_next     = data_reg;
      samp_a_next   = samp_a_reg;
      manch_next    = manch_reg;
      rx_data_next  = rx_data_reg;
      rx_cmd_next   = rx_cmd_reg;
      rx_valid_next = 1'b0;
      rx_manch_next = rx_manch_reg;
      rx_par_next   = rx_par_reg;
      rx_busy_next  = rx_busy_reg;
      case (state_reg)
         S_HUNT: begin
            if (!act_s) begin
               run_next = '0;
            end else if (edge_s) begin
               run_next = CNT_W'(1);
               // A long enough run ending in a level change is the sync mid-edge.
               if (run_reg >= RUN_MIN && run_reg <= RUN_MAX) begin
                  pol_next     = lvl_d;
                  phase_next   = '0;
                  manch_next   = 1'b0;
                  rx_busy_next = 1'b1;
                  state_next   = S_SYNC2;
               end
            end else if (run_reg != '1) begin
               run_next = run_reg + CNT_W'(1);
            end
         end
         S_SYNC2: begin
            phase_next = phase_reg + CNT_W'(1);
            if ((phase_reg == SAMP_1 || phase_reg == SAMP_3 || phase_reg == SAMP_5) &&
                !(act_d && (lvl_d == ~pol_reg))) begin
               run_next     = '0;
               rx_busy_next = 1'b0;
               state_next   = S_HUNT;
            end else if (phase_reg == SYNC_END) begin
               phase_next   = '0;
               bit_idx_next = 5'd16;
               state_next   = S_DATA;
            end
         end
         S_DATA: begin
            phase_next = phase_reg + CNT_W'(1);
            if (edge_s && phase_reg >= WIN_LO && phase_reg <= WIN_HI)
               phase_next = H;
            if (phase_reg == SAMP_1) begin
               samp_a_next = lvl_d;
               if (!act_d)
                  manch_next = 1'b1;
            end
            if (phase_reg == SAMP_3) begin
               if (!act_d || (lvl_d == samp_a_reg))
                  manch_next = 1'b1;
               // Index 0 is the parity bit; the word completes on its second sample.
               if (bit_idx_reg == 5'd0) begin
                  rx_data_next  = data_reg;
                  rx_cmd_next   = pol_reg;
                  rx_manch_next = manch_next;
                  rx_par_next   = ~(^data_reg ^ samp_a_reg);
                  rx_valid_next = 1'b1;
                  rx_busy_next  = 1'b0;
                  state_next    = S_DONE;
               end
            end
            if (phase_reg == BIT_END) begin
               phase_next   = '0;
               data_next    = {data_reg[14:0], samp_a_reg};
               bit_idx_next = bit_idx_reg - 5'd1;
            end
         end
         S_DONE: begin
            run_next   = '0;
            state_next = S_HUNT;
         end
         default: state_next = S_HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         di_meta_reg  <= '0;
         di_sync_reg  <= '0;
         di_dly_reg   <= '0;
         state_reg    <= S_HUNT;
         run_reg      <= '0;
         phase_reg    <= '0;
         bit_idx_reg  <= '0;
         pol_reg      <= 1'b0;
         data_reg     <= '0;
         samp_a_reg   <= 1'b0;
         manch_reg    <= 1'b0;
         rx_data_reg  <= '0;
         rx_cmd_reg   <= 1'b0;
         rx_valid_reg <= 1'b0;
         rx_manch_reg <= 1'b0;
         rx_par_reg   <= 1'b0;
         rx_busy_reg  <= 1'b0;
      end else begin
         di_meta_reg  <= {DI1, DI0};
         di_sync_reg  <= di_meta_reg;
         di_dly_reg   <= di_sync_reg;
         state_reg    <= state_next;
         run_reg      <= run_next;
         phase_reg    <= phase_next;
         bit_idx_reg  <= bit_idx_next;
         pol_reg      <= pol_next;
         data_reg     <= data_next;
         samp_a_reg   <= samp_a_next;
         manch_reg    <= manch_next;
         rx_data_reg  <= rx_data_next;
         rx_cmd_reg   <= rx_cmd_next;
         rx_valid_reg <= rx_valid_next;
         rx_manch_reg <= rx_manch_next;
         rx_par_reg   <= rx_par_next;
         rx_busy_reg  <= rx_busy_next;
      end
   end

   assign rx_data      = rx_data_reg;
   assign rx_cmd       = rx_cmd_reg;
   assign rx_valid     = rx_valid_reg;
   assign rx_manch_err = rx_manch_reg;
   assign rx_par_err   = rx_par_reg;
   assign rx_busy      = rx_busy_reg;

endmodule

// File: tb/tb_mkio_word_decoder.sv
// Bench for mkio_word_decoder: drives Manchester frames on DI1/DI0 and checks
// each strobed word against fixed vectors and a parity/violation reference model.
module tb_mkio_word_decoder;

   localparam int H   = 16;
   localparam int TOL = 4;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        DI1   = 1'b0;
   logic        DI0   = 1'b0;
   logic [15:0] rx_data;
   logic        rx_cmd, rx_valid, rx_manch_err, rx_par_err, rx_busy;

   mkio_word_decoder #(.CLK_PER_HALF(H), .TOL(TOL), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .DI1(DI1), .DI0(DI0),
      .rx_data(rx_data), .rx_cmd(rx_cmd), .rx_valid(rx_valid),
      .rx_manch_err(rx_manch_err), .rx_par_err(rx_par_err), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] data;
      logic        cmd;
      logic        manch;
      logic        par;
      int          t;
   } strobe_t;

   strobe_t sq[$];
   int      busy_cycles = 0;

   always @(negedge clk) begin
      strobe_t s;
      if (rx_valid) begin
         s.data  = rx_data;
         s.cmd   = rx_cmd;
         s.manch = rx_manch_err;
         s.par   = rx_par_err;
         s.t     = cyc;
         sq.push_back(s);
      end
      if (rx_busy) busy_cycles++;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Line drive, always entered and left on a falling clock edge.
   task automatic drive(input logic d1, input logic d0, input int n);
      DI1 = d1;
      DI0 = d0;
      repeat (n) @(negedge clk);
   endtask

   int          last_mid;
   logic [15:0] snap_data;
   logic [4:0]  snap_flags;

   // One 20-bit frame: 3 sync halves per level, 16 Manchester bits, odd parity.
   // vbit >= 0 drives both halves of that data bit high; rst_k pulses reset at that half.
   task automatic send_word(input logic [15:0] data, input logic cmd, input logic flip,
                            input int vbit, input bit jit, input int rst_k);
      logic lv [40];
      int   b  [41];
      logic p;
      p = ~(^data) ^ flip;
      for (int k = 0; k < 3; k++) begin
         lv[k]     = cmd;
         lv[k + 3] = ~cmd;
      end
      for (int i = 0; i < 16; i++) begin
         lv[6 + 2 * i] = data[15 - i];
         lv[7 + 2 * i] = ~data[15 - i];
         if (15 - i == vbit) begin
            lv[6 + 2 * i] = 1'b1;
            lv[7 + 2 * i] = 1'b1;
         end
      end
      lv[38] = p;
      lv[39] = ~p;
      for (int k = 0; k <= 40; k++)
         b[k] = k * H + ((jit && k > 0 && k < 40) ? int'($urandom_range(6)) - 3 : 0);
      for (int k = 0; k < 40; k++) begin
         if (k == 3) last_mid = cyc;
         if (k == rst_k) begin
            DI1   = lv[k];
            DI0   = ~lv[k];
            reset = 1'b0;
            @(negedge clk);
            reset      = 1'b1;
            snap_data  = rx_data;
            snap_flags = {rx_cmd, rx_valid, rx_manch_err, rx_par_err, rx_busy};
            drive(lv[k], ~lv[k], b[k + 1] - b[k] - 1);
         end else begin
            drive(lv[k], ~lv[k], b[k + 1] - b[k]);
         end
      end
      drive(1'b0, 1'b0, 0);
   endtask

   task automatic get_strobe(output bit got, output strobe_t s);
      int t = 0;
      got = 0;
      s.data = '0; s.cmd = 0; s.manch = 0; s.par = 0; s.t = 0;
      while (sq.size() == 0 && t < 64) begin
         @(negedge clk);
         t++;
      end
      if (sq.size() > 0) begin
         s   = sq.pop_front();
         got = 1;
      end
   endtask

   task automatic check_word(input string tag, input logic [15:0] ed, input logic ec,
                             input logic ep, input logic em, output strobe_t s);
      bit got;
      get_strobe(got, s);
      check({tag, "_strobe"}, got, 1);
      if (got) begin
         $display("word %s: data=%h cmd=%0d manch=%0d par=%0d t=%0d",
                  tag, s.data, s.cmd, s.manch, s.par, s.t);
         check({tag, "_data"}, s.data, ed);
         check({tag, "_cmd"}, s.cmd, ec);
         check({tag, "_par_err"}, s.par, ep);
         check({tag, "_manch_err"}, s.manch, em);
      end
   endtask

   // Reference: decoded word takes a forced-high violation bit as 1; parity is
   // judged by counting ones of what was decoded plus the parity bit sent.
   function automatic void model(input logic [15:0] d, input logic flip, input int vbit,
                                 output logic [15:0] ed, output logic ep, output logic em);
      int   ones_sent = 0;
      int   ones_dec  = 0;
      logic pbit;
      ed = d;
      if (vbit >= 0) ed[vbit] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ones_sent += int'(d[i]);
         ones_dec  += int'(ed[i]);
      end
      pbit = ((ones_sent % 2) == 0) ? 1'b1 : 1'b0;
      if (flip) pbit = ~pbit;
      ep = (((ones_dec + int'(pbit)) % 2) == 0);
      em = (vbit >= 0);
   endfunction

   typedef struct {
      logic [15:0] data;
      logic        cmd;
      logic        flip;
      int          vbit;
      bit          jit;
      logic [15:0] exp_data;
      logic        exp_cmd;
      logic        exp_par;
      logic        exp_manch;
   } vec_t;

   initial begin
      vec_t    vt [6];
      strobe_t s1, s2;
      int      lat, b0, mid1;
      string   tag;

      vt[0] = '{16'h0867, 1'b1, 1'b0, -1, 1'b0, 16'h0867, 1'b1, 1'b0, 1'b0};
      vt[1] = '{16'hA5C3, 1'b0, 1'b0, -1, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0};
      vt[2] = '{16'h00FF, 1'b0, 1'b1, -1, 1'b0, 16'h00FF, 1'b0, 1'b1, 1'b0};
      vt[3] = '{16'h1234, 1'b0, 1'b0,  7, 1'b0, 16'h12B4, 1'b0, 1'b1, 1'b1};
      vt[4] = '{16'h0000, 1'b1, 1'b0, -1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
      vt[5] = '{16'hFFFF, 1'b0, 1'b0, -1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

      repeat (4) @(negedge clk);
      check("reset_rx_data", rx_data, 16'h0000);
      check("reset_rx_cmd", rx_cmd, 0);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_manch_err", rx_manch_err, 0);
      check("reset_rx_par_err", rx_par_err, 0);
      check("reset_rx_busy", rx_busy, 0);
      reset = 1'b1;
      drive(1'b0, 1'b0, 20);

      // Command word with ideal timing: latency and busy duration.
      b0 = busy_cycles;
      send_word(16'h0867, 1'b1, 1'b0, -1, 1'b0, -1);
      mid1 = last_mid;
      check_word("cmd", 16'h0867, 1'b1, 1'b0, 1'b0, s1);
      lat = s1.t - mid1;
      n_checks++;
      if (lat < 587 - 2 || lat > 587 + 2) begin
         n_fail++;
         $display("FAIL cmd_latency: got %0d clocks, expected 587 +/- 2", lat);
      end
      check("cmd_busy_cycles", busy_cycles - b0, 36 * H + H / 2 + 1);
      drive(1'b0, 1'b0, 30);

      // Back-to-back command then data word, no gap.
      send_word(16'h0867, 1'b1, 1'b0, -1, 1'b0, -1);
      send_word(16'hA5C3, 1'b0, 1'b0, -1, 1'b0, -1);
      drive(1'b0, 1'b0, 10);
      check_word("b2b_first", 16'h0867, 1'b1, 1'b0, 1'b0, s1);
      check_word("b2b_second", 16'hA5C3, 1'b0, 1'b0, 1'b0, s2);
      check("b2b_spacing", s2.t - s1.t, 40 * H);
      drive(1'b0, 1'b0, 30);

      for (int i = 0; i < 6; i++) begin
         send_word(vt[i].data, vt[i].cmd, vt[i].flip, vt[i].vbit, vt[i].jit, -1);
         drive(1'b0, 1'b0, 20);
         tag = $sformatf("vec%0d", i);
         check_word(tag, vt[i].exp_data, vt[i].exp_cmd, vt[i].exp_par, vt[i].exp_manch, s1);
      end

      // Short sync: first half only 2H, then 3H of the other level, then idle.
      b0 = busy_cycles;
      drive(1'b1, 1'b0, 2 * H);
      drive(1'b0, 1'b1, 3 * H);
      drive(1'b0, 1'b0, 60);
      check("short_sync_no_strobe", sq.size(), 0);
      check("short_sync_busy", busy_cycles - b0, 0);
      $display("short sync: strobes=%0d busy_cycles=%0d", sq.size(), busy_cycles - b0);

      // Reset pulse at the start of data bit 8 of a word.
      send_word(16'h5A5A, 1'b1, 1'b0, -1, 1'b0, 6 + 2 * (15 - 8));
      check("midreset_rx_data", snap_data, 16'h0000);
      check("midreset_flags", snap_flags, 5'b00000);
      drive(1'b0, 1'b0, 60);
      check("midreset_no_strobe", sq.size(), 0);
      $display("mid-word reset: data=%h flags=%b strobes=%0d", snap_data, snap_flags, sq.size());
      send_word(16'h3C5A, 1'b0, 1'b0, -1, 1'b0, -1);
      drive(1'b0, 1'b0, 20);
      check_word("after_reset", 16'h3C5A, 1'b0, 1'b0, 1'b0, s1);

      // Randomized words against the reference model.
      for (int i = 0; i < 24; i++) begin
         logic [15:0] d, ed;
         logic        c, f, ep, em;
         int          vb;
         bit          j;
         d  = 16'($urandom);
         c  = 1'($urandom_range(1));
         f  = ($urandom_range(3) == 0);
         vb = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1;
         j  = 1'($urandom_range(1));
         model(d, f, vb, ed, ep, em);
         send_word(d, c, f, vb, j, -1);
         drive(1'b0, 1'b0, 20);
         tag = $sformatf("rnd%0d", i);
         check_word(tag, ed, c, ep, em, s1);
      end

      drive(1'b0, 1'b0, 20);
      check("no_extra_strobes", sq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
